// File: rtl/microwave_nivel1.sv
// microwave_nivel1: level-1 microwave oven controller.
// Takes a three-digit BCD cooking time from a one-hot keypad, counts it down
// once per second while cooking, and drives a four-digit active-low display.
module microwave_nivel1 #(
  parameter int CLK_HZ = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] key,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic [6:0] blank_digit,
  output logic [6:0] min_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] sec_ones_segs,
  output logic       mag_on
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, COOK, PAUSE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    min_reg, min_next;
  logic [3:0]    tens_reg, tens_next;
  logic [3:0]    ones_reg, ones_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [9:0]    prev_key_reg;

  // Helper terms for the next-state logic
  logic       key_evt;
  logic [3:0] key_digit;
  logic       time_zero;
  logic       sec_tick;
  logic       start_ok;
  logic       halt_req;
  logic [3:0] dec_min, dec_tens, dec_ones;

  // Find the highest pressed key, which is the digit entered on a key event
  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) key_digit = 4'(i);
    end
  end

  assign key_evt   = (key != 10'd0) && (prev_key_reg == 10'd0);
  assign time_zero = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);
  assign sec_tick  = (presc_reg == PRESC_LAST);
  assign start_ok  = !startn && stopn && door_closed && !time_zero;
  assign halt_req  = !stopn || !door_closed;

  // One-second decrement with BCD borrow; tens restarts at 5 so entered
  // values above 5 in the tens place still count down literally
  always_comb begin
    dec_min  = min_reg;
    dec_tens = tens_reg;
    dec_ones = ones_reg;
    if (ones_reg != 4'd0) begin
      dec_ones = ones_reg - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_reg != 4'd0) begin
        dec_tens = tens_reg - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_reg - 4'd1;
      end
    end
  end

  // State, time and prescaler registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      min_reg      <= 4'd0;
      tens_reg     <= 4'd0;
      ones_reg     <= 4'd0;
      presc_reg    <= '0;
      prev_key_reg <= 10'd0;
    end else begin
      state_reg    <= state_next;
      min_reg      <= min_next;
      tens_reg     <= tens_next;
      ones_reg     <= ones_next;
      presc_reg    <= presc_next;
      prev_key_reg <= key;
    end
  end

  // Next-state logic: clear beats everything, then pause, start, completion
  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    presc_next = presc_reg;
    if (!clearn) begin
      state_next = IDLE;
      min_next   = 4'd0;
      tens_next  = 4'd0;
      ones_next  = 4'd0;
      presc_next = '0;
    end else begin
      case (state_reg)
        COOK: begin
          if (halt_req) begin
            // The tick on the pausing edge is dropped
            state_next = PAUSE;
          end else if (sec_tick) begin
            presc_next = '0;
            min_next   = dec_min;
            tens_next  = dec_tens;
            ones_next  = dec_ones;
            if (dec_min == 4'd0 && dec_tens == 4'd0 && dec_ones == 4'd0) begin
              state_next = IDLE;
            end
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
        default: begin
          // Start is judged on the time before any key shifted in this cycle
          if (key_evt) begin
            min_next  = tens_reg;
            tens_next = ones_reg;
            ones_next = key_digit;
          end
          if (start_ok) begin
            state_next = COOK;
            presc_next = '0;
          end
        end
      endcase
    end
  end

  // Magnetron enable and the unused display digit
  always_comb begin
    mag_on      = (state_reg == COOK);
    blank_digit = 7'b1111111;
  end

  // Active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] val);
    case (val)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [3:0] digit_val [3];
  logic [6:0] seg_val   [3];

  assign digit_val[0] = min_reg;
  assign digit_val[1] = tens_reg;
  assign digit_val[2] = ones_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_decode
      assign seg_val[gi] = seg7(digit_val[gi]);
    end
  endgenerate

  assign min_segs      = seg_val[0];
  assign sec_tens_segs = seg_val[1];
  assign sec_ones_segs = seg_val[2];

endmodule

// File: tb/tb_microwave_nivel1.sv
// Bench for microwave_nivel1: directed scenarios followed by random stimulus,
// checked every cycle against a decimal-number model of the oven.
module tb_microwave_nivel1;

  localparam int HZ = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] key = 10'd0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic [6:0] blank_digit, min_segs, sec_tens_segs, sec_ones_segs;
  logic       mag_on;

  int total = 0;
  int bad = 0;

  microwave_nivel1 #(.CLK_HZ(HZ)) dut (
    .clock(clock), .reset(reset), .key(key), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .blank_digit(blank_digit),
    .min_segs(min_segs), .sec_tens_segs(sec_tens_segs),
    .sec_ones_segs(sec_ones_segs), .mag_on(mag_on)
  );

  always #5 clock = ~clock;

  // Glyph table for digits 0..9
  logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

  // Model: displayed time as the decimal number M*100 + T*10 + O
  int         m_time;
  bit         m_cook;
  int         m_cycles;
  logic [9:0] m_prev;

  always @(posedge clock or posedge reset) begin : model
    int  t;
    bit  c;
    int  n;
    int  dig;
    if (reset) begin
      m_time   <= 0;
      m_cook   <= 1'b0;
      m_cycles <= 0;
      m_prev   <= 10'd0;
    end else begin
      t = m_time;
      c = m_cook;
      n = m_cycles;
      if (!clearn) begin
        t = 0; c = 1'b0; n = 0;
      end else if (c) begin
        if (!stopn || !door_closed) begin
          c = 1'b0;
        end else begin
          n = n + 1;
          if (n == HZ) begin
            n = 0;
            t = (t % 100 == 0) ? t - 41 : t - 1;
            if (t == 0) c = 1'b0;
          end
        end
      end else begin
        bit go;
        go = !startn && stopn && door_closed && (t != 0);
        if (key != 10'd0 && m_prev == 10'd0) begin
          dig = 0;
          for (int i = 0; i < 10; i++) if (key[i]) dig = i;
          t = (t * 10 + dig) % 1000;
        end
        if (go) begin
          c = 1'b1; n = 0;
        end
      end
      m_time   <= t;
      m_cook   <= c;
      m_cycles <= n;
      m_prev   <= key;
    end
  end

  task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (!reset) begin
      cmp("mag_on", {6'd0, mag_on}, {6'd0, m_cook});
      cmp("blank", blank_digit, 7'b1111111);
      cmp("min", min_segs, glyph[(m_time / 100) % 10]);
      cmp("tens", sec_tens_segs, glyph[(m_time / 10) % 10]);
      cmp("ones", sec_ones_segs, glyph[m_time % 10]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic enter(input int dig);
    key = 10'd1 << dig;
    tick(1);
    key = 10'd0;
    tick(1);
  endtask

  task automatic lit(input string tag, input logic mg, input logic [6:0] mn,
                     input logic [6:0] tn, input logic [6:0] on);
    cmp({tag, "_mag"}, {6'd0, mag_on}, {6'd0, mg});
    cmp({tag, "_min"}, min_segs, mn);
    cmp({tag, "_tens"}, sec_tens_segs, tn);
    cmp({tag, "_ones"}, sec_ones_segs, on);
    $display("check %s: mag=%b %b %b %b", tag, mag_on, min_segs, sec_tens_segs, sec_ones_segs);
  endtask

  initial begin
    tick(3);
    lit("in_reset", 1'b0, 7'b1000000, 7'b1000000, 7'b1000000);
    cmp("reset_blank", blank_digit, 7'b1111111);
    reset = 1'b0;
    tick(2);

    // Entry of 0:40
    enter(4);
    enter(0);
    lit("entry_040", 1'b0, 7'b1000000, 7'b0011001, 7'b1000000);

    // Door interlock
    door_closed = 1'b0; startn = 1'b0;
    tick(3);
    lit("door_open", 1'b0, 7'b1000000, 7'b0011001, 7'b1000000);
    door_closed = 1'b1;
    tick(1);
    lit("start", 1'b1, 7'b1000000, 7'b0011001, 7'b1000000);
    startn = 1'b1;
    tick(99);
    lit("pre_tick", 1'b1, 7'b1000000, 7'b0011001, 7'b1000000);
    tick(1);
    lit("first_dec", 1'b1, 7'b1000000, 7'b0110000, 7'b0010000);

    // Pause and resume
    tick(1900);
    stopn = 1'b0;
    tick(1);
    lit("paused", 1'b0, 7'b1000000, 7'b0100100, 7'b1000000);
    tick(50);
    lit("held", 1'b0, 7'b1000000, 7'b0100100, 7'b1000000);
    stopn = 1'b1; startn = 1'b0;
    tick(1);
    lit("resumed", 1'b1, 7'b1000000, 7'b0100100, 7'b1000000);
    startn = 1'b1;
    tick(30);
    door_closed = 1'b0;
    tick(1);
    cmp("door_pause", {6'd0, mag_on}, 7'd0);
    door_closed = 1'b1; startn = 1'b0;
    tick(1);
    cmp("door_resume", {6'd0, mag_on}, 7'd1);

    // Completion with start held low
    tick(2200);
    lit("done", 1'b0, 7'b1000000, 7'b1000000, 7'b1000000);
    startn = 1'b1;

    // Clear during cooking
    enter(4);
    enter(0);
    startn = 1'b0;
    tick(1);
    startn = 1'b1;
    tick(10);
    clearn = 1'b0;
    tick(1);
    lit("cleared", 1'b0, 7'b1000000, 7'b1000000, 7'b1000000);
    clearn = 1'b1;
    enter(4);
    enter(0);
    startn = 1'b0;
    tick(1);
    lit("restart", 1'b1, 7'b1000000, 7'b0011001, 7'b1000000);
    startn = 1'b1;
    clearn = 1'b0;
    tick(1);
    clearn = 1'b1;

    // Minute borrow, then asynchronous reset mid-cook
    enter(1);
    enter(0);
    enter(0);
    startn = 1'b0;
    tick(1);
    startn = 1'b1;
    tick(100);
    lit("borrow", 1'b1, 7'b1000000, 7'b0010010, 7'b0010000);
    #1 reset = 1'b1;
    #1;
    lit("async_rst", 1'b0, 7'b1000000, 7'b1000000, 7'b1000000);
    tick(2);
    reset = 1'b0;
    tick(1);

    // Random phase
    for (int cyc = 0; cyc < 20000; cyc++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) key = 10'd1 << $urandom_range(0, 9);
      else if (r < 10) key = 10'($urandom);
      else key = 10'd0;
      startn      = ($urandom_range(0, 99) >= 20);
      stopn       = ($urandom_range(0, 99) >= 3);
      door_closed = ($urandom_range(0, 99) >= 3);
      clearn      = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 1999) == 0) begin
        #1 reset = 1'b1;
        #2 reset = 1'b0;
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
